// File: rtl/cabin_reg_bank.sv
// cabin_reg_bank: multi-channel register bank with staged writes and atomic commit.
// Writes land in per-channel shadow registers; a commit pulse moves every pending
// shadow to the live outputs on one edge, and an abort restores shadows from live.
// Optional readback port block enabled by defining CABIN_REG_READBACK_EN.
module cabin_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(CHANNELS)-1:0]   wr_sel,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          commit,
  input  logic                          abort,
  output logic [CHANNELS*WIDTH-1:0]     q,
  output logic [CHANNELS-1:0]           pending,
  output logic                          staged,
  output logic [CHANNELS-1:0]           changed,
  output logic                          sel_err
`ifdef CABIN_REG_READBACK_EN
  ,
  input  logic [$clog2(CHANNELS)-1:0]   rd_sel,
  input  logic                          rd_shadow,
  output logic [WIDTH-1:0]              rd_data
`endif
);

  typedef enum logic {IDLE, STAGED} state_e;

  state_e                           state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   live_q, live_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [CHANNELS-1:0]              pending_q, pending_d;
  logic [CHANNELS-1:0]              changed_q, changed_d;
  logic                             selErr_q, selErr_d;
  logic                             validWr;
  logic [CHANNELS-1:0]              wrHit;

  // Decode the write target into a one-hot hit vector; out-of-range selects hit nothing.
  always_comb begin
    validWr = wr_en && (int'(wr_sel) < CHANNELS);
    wrHit   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      wrHit[n] = validWr && (int'(wr_sel) == n);
    end
  end

  // Datapath next state: abort beats commit, and a same-cycle write joins a commit
  // but is dropped by an abort. Shadows of non-pending channels always mirror live.
  always_comb begin
    live_d    = live_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    changed_d = '0;
    selErr_d  = wr_en && !validWr;
    if (abort) begin
      pending_d = '0;
      shadow_d  = live_q;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (wrHit[n]) begin
          shadow_d[n]  = wr_data;
          pending_d[n] = 1'b1;
        end
      end
      if (commit) begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (pending_d[n]) begin
            live_d[n]    = shadow_d[n];
            changed_d[n] = (shadow_d[n] != live_q[n]);
          end
        end
        pending_d = '0;
      end
    end
  end

  // FSM next state: a lone valid write opens a transaction, commit or abort closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (validWr && !commit && !abort) state_d = STAGED;
      STAGED:  if (commit || abort)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      live_q    <= {CHANNELS{RESET_VAL}};
      shadow_q  <= {CHANNELS{RESET_VAL}};
      pending_q <= '0;
      changed_q <= '0;
      selErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      changed_q <= changed_d;
      selErr_q  <= selErr_d;
    end
  end

  assign q       = live_q;
  assign pending = pending_q;
  assign staged  = (state_q == STAGED);
  assign changed = changed_q;
  assign sel_err = selErr_q;

`ifdef CABIN_REG_READBACK_EN
  logic [WIDTH-1:0] rdData_q, rdData_d;

  // Readback mux: shadow or live copy of the selected channel, zero when out of range.
  always_comb begin
    rdData_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (int'(rd_sel) == n) rdData_d = rd_shadow ? shadow_q[n] : live_q[n];
    end
  end

  // Readback register gives the one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) rdData_q <= '0;
    else       rdData_q <= rdData_d;
  end

  assign rd_data = rdData_q;
`endif

endmodule
